// File: rtl/jpc_ifetch.sv
// JPC instruction fetch: PC generation, credit-limited fetch issue, in-order
// response FIFO toward decode, and redirect flush of buffered/in-flight fetches.
module jpc_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_I,
    input  logic        rstn_I,
    output logic        imem_req_O,
    output logic [31:0] imem_addr_O,
    input  logic        imem_gnt_I,
    input  logic        imem_rvalid_I,
    input  logic [31:0] imem_rdata_I,
    input  logic        imem_err_I,
    input  logic        redirect_I,
    input  logic [31:0] redirect_pc_I,
    output logic        instr_valid_O,
    output logic [31:0] instr_O,
    output logic [31:0] pc_O,
    output logic        fetch_err_O,
    input  logic        instr_ready_I
);

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam logic [CW1-1:0] DEPTH_CREDIT = CW1'(DEPTH);
    localparam logic [CW-1:0]  DEPTH_CNT    = CW'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] pending_q, pending_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] fifo_pc_q    [DEPTH];
    logic [31:0] fifo_instr_q [DEPTH];
    logic        fifo_err_q   [DEPTH];

    logic           pop;
    logic           push;
    logic           grant;
    logic           drop;
    logic [CW1-1:0] credit_used;
    logic [31:0]    resp_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign instr_valid_O = (count_q != '0);
    assign pop           = instr_valid_O & instr_ready_I;
    assign credit_used   = {1'b0, pending_q} + {1'b0, count_q} - CW1'(pop);
    assign imem_req_O    = rstn_I & ~redirect_I & (credit_used < DEPTH_CREDIT);
    assign imem_addr_O   = fetch_pc_q;
    assign grant         = imem_req_O & imem_gnt_I;
    assign drop          = imem_rvalid_I & (discard_q != '0);
    assign push          = imem_rvalid_I & ~drop & ~redirect_I;

    // Once stale responses are drained, every pending fetch is sequential and
    // ends just below fetch_pc, so the oldest one sits 4*pending bytes back.
    assign resp_pc = fetch_pc_q - {{(30 - CW){1'b0}}, pending_q, 2'b00};

    assign instr_O     = instr_valid_O ? fifo_instr_q[rd_ptr_q] : 32'h0000_0013;
    assign pc_O        = instr_valid_O ? fifo_pc_q[rd_ptr_q]    : 32'h0000_0000;
    assign fetch_err_O = instr_valid_O & fifo_err_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pending_d  = pending_q;
        discard_d  = discard_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirect_I) begin
            // No grant can coincide with a redirect, so only rvalid retires.
            fetch_pc_d = {redirect_pc_I[31:2], 2'b00};
            pending_d  = pending_q - CW'(imem_rvalid_I);
            discard_d  = pending_q - CW'(imem_rvalid_I);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            pending_d = pending_q + CW'(grant) - CW'(imem_rvalid_I);
            if (drop) begin
                discard_d = discard_q - CW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clk_I or negedge rstn_I) begin
        if (!rstn_I) begin
            fetch_pc_q <= RESET_PC;
            pending_q  <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pending_q  <= pending_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk_I) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= resp_pc;
            fifo_instr_q[wr_ptr_q] <= imem_rdata_I;
            fifo_err_q[wr_ptr_q]   <= imem_err_I;
        end
    end

    a_no_overflow: assert property (@(posedge clk_I) disable iff (!rstn_I)
        !(push && !pop && (count_q == DEPTH_CNT)));

    a_discard_bounded: assert property (@(posedge clk_I) disable iff (!rstn_I)
        discard_q <= pending_q);

endmodule
